// File: rtl/ssd_scan_sched.sv
// Four-digit seven-segment scan controller with per-frame source snapshot and rotation.
// Optional leading-zero suppression when SSD_LZ_BLANK_EN is defined.
module ssd_scan_sched #(
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter int unsigned BLANK_CYC     = 16,
   parameter int unsigned ROTATE_FRAMES = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] src0,
   input  logic [15:0] src1,
   input  logic [15:0] src2,
   input  logic [15:0] src3,
   input  logic [1:0]  sel,
   input  logic        auto_en,
   input  logic        hold,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  cur_src
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned FW = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;

   typedef enum logic {BLANK, SHOW} state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [1:0]     dig, dig_nx;
   logic [FW-1:0]  frm, frm_nx;
   logic [15:0]    shadow, shadow_nx;
   logic [1:0]     cur_src_nx;
   logic [3:0]     an_nx;
   logic [6:0]     seg_nx;
   logic           dp_nx;
   logic           wrap;
   logic [3:0]     nib;

   assign wrap = (cnt == CW'(REFRESH_DIV - 1));
   assign nib  = shadow[{dig, 2'b00} +: 4];

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0: decode = 7'h01;
         4'h1: decode = 7'h4F;
         4'h2: decode = 7'h12;
         4'h3: decode = 7'h06;
         4'h4: decode = 7'h4C;
         4'h5: decode = 7'h24;
         4'h6: decode = 7'h20;
         4'h7: decode = 7'h0F;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h04;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h60;
         4'hC: decode = 7'h31;
         4'hD: decode = 7'h42;
         4'hE: decode = 7'h30;
         default: decode = 7'h38;
      endcase
   endfunction

`ifdef SSD_LZ_BLANK_EN
   // Digit is a leading zero when it and every higher nibble are zero.
   logic lz;
   always_comb begin
      case (dig)
         2'd1:    lz = (shadow[15:4] == 12'h000);
         2'd2:    lz = (shadow[15:8] == 8'h00);
         2'd3:    lz = (shadow[15:12] == 4'h0);
         default: lz = 1'b0;
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= BLANK;
         cnt     <= '0;
         dig     <= '0;
         frm     <= '0;
         shadow  <= '0;
         cur_src <= '0;
         an      <= 4'hF;
         seg     <= 7'h7F;
         dp      <= 1'b1;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         dig     <= dig_nx;
         frm     <= frm_nx;
         shadow  <= shadow_nx;
         cur_src <= cur_src_nx;
         an      <= an_nx;
         seg     <= seg_nx;
         dp      <= dp_nx;
      end
   end

   always_comb begin
      cnt_nx     = cnt + CW'(1);
      dig_nx     = dig;
      state_nx   = state;
      frm_nx     = frm;
      cur_src_nx = cur_src;
      shadow_nx  = shadow;
      an_nx      = 4'hF;
      seg_nx     = 7'h7F;
      dp_nx      = 1'b1;

      if (wrap) begin
         cnt_nx = '0;
         dig_nx = dig + 2'd1;
      end

      case (state)
         BLANK:   if (cnt_nx == CW'(BLANK_CYC)) state_nx = SHOW;
         SHOW:    if (wrap) state_nx = BLANK;
         default: state_nx = BLANK;
      endcase

      // Frame boundary: pick the source and snapshot it for the whole next frame.
      if (wrap && (dig == 2'd3)) begin
         if (auto_en) begin
            if (frm == FW'(ROTATE_FRAMES - 1)) begin
               frm_nx     = '0;
               cur_src_nx = cur_src + 2'd1;
            end else begin
               frm_nx = frm + FW'(1);
            end
         end else begin
            frm_nx     = '0;
            cur_src_nx = sel;
         end
         if (!hold) begin
            case (cur_src_nx)
               2'd0:    shadow_nx = src0;
               2'd1:    shadow_nx = src1;
               2'd2:    shadow_nx = src2;
               default: shadow_nx = src3;
            endcase
         end
      end

      if (state == SHOW) begin
         an_nx  = ~(4'b0001 << dig);
         seg_nx = decode(nib);
         dp_nx  = (dig != cur_src);
`ifdef SSD_LZ_BLANK_EN
         if (lz) seg_nx = 7'h7F;
`endif
      end
   end

endmodule

// File: doc/ssd_scan_sched.md
# ssd_scan_sched

Scan controller and source scheduler for the board's 4-digit, common-anode seven-segment display. It time-multiplexes the four digits, with an anti-ghosting blank interval at each digit change. It shares the single display between four 16-bit requesters (e.g. PC, ALU result, register read, memory data), selected either manually or by automatic rotation. The displayed value is snapshotted once per frame, so the four digits are always mutually consistent. It sits between the pipeline's debug taps and the board pins.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot; must be at least 4.
- BLANK_CYC, 16: cycles at the start of each slot during which all anodes are off; must be at least 1 and less than REFRESH_DIV.
- ROTATE_FRAMES, 200: full 4-digit frames per source dwell in auto mode; must be at least 1.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- src0, src1, src2, src3  in  16 each  requester values; hex digit n is bits [4n+3:4n]
- sel  in  2  manual source select
- auto_en  in  1  1 = rotate sources, 0 = use sel
- hold  in  1  1 = freeze the snapshot; scanning continues
- an  out  4  anode enables, active-low; bit n drives digit n
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low
- dp  out  1  decimal point, active-low
- cur_src  out  2  index of the source currently shown

## Operation
- Prescaler `cnt` runs 0 to REFRESH_DIV-1 and wraps. At the wrap, the 2-bit digit counter `dig` increments, 3 to 0 modulo.
- Slot state machine:
  - BLANK while cnt < BLANK_CYC: an = 4'hF.
  - SHOW otherwise: an has only bit `dig` low.
  - Transitions: BLANK to SHOW at cnt == BLANK_CYC; SHOW to BLANK at cnt wrap.
- Frame boundary: the cycle with dig == 3 and cnt == REFRESH_DIV-1. Only on this edge:
  - cur_src update:
    - auto_en = 0: cur_src <= sel.
    - auto_en = 1: frame counter `frm` increments; when frm reaches ROTATE_FRAMES-1, frm <= 0 and cur_src <= cur_src+1, wrapping 3 to 0.
    - auto_en = 0 holds frm at 0.
  - Snapshot: shadow <= src[next cur_src], unless hold = 1, in which case shadow is unchanged.
- Changes to sel, auto_en, hold or src mid-frame have no visible effect before the next boundary.
- Decode of shadow nibble `dig`, as a 7-bit value, by nibble 0 to F: 01, 4F, 12, 06, 4C, 24, 20, 0F, 00, 04, 08, 60, 31, 42, 30, 38.
- dp is 0 in SHOW when dig == cur_src; otherwise dp = 1. This marks the active source.
- In BLANK: seg = 7'h7F and dp = 1.

## Timing
- Reset values:
  - State: cnt = 0, dig = 0, frm = 0, shadow = 0, state BLANK.
  - Outputs: an = 4'hF, seg = 7'h7F, dp = 1, cur_src = 0.
- All outputs are registered and reflect the counter state of the previous cycle: one cycle of latency from a cnt/dig change to the pin.
- rst asserted mid-slot or mid-frame returns every register to its reset value on that edge. Scanning restarts at digit 0 in BLANK.
- Source change latency: a sel change is shown from the start of the next frame, i.e. at most 4*REFRESH_DIV+1 cycles later.
- Simultaneous rotation and hold at a boundary: cur_src advances, shadow keeps its old value. The displayed digits stay stale until hold drops and the next boundary occurs.
- An anode is never low in two consecutive slots without BLANK_CYC all-off cycles in between.

## Configuration
- SSD_LZ_BLANK_EN defined: leading-zero suppression.
  - In SHOW, digit n (n = 1..3) outputs seg = 7'h7F if it and all higher nibbles of shadow are 0.
  - Digit 0 is always shown.
  - dp behaviour is unchanged.
- Not defined: all four digits are always shown, including zeros.

## Test plan
- Reset: hold rst for 3 cycles -> an = F, seg = 7F, dp = 1, cur_src = 0. First anode low (an = E) appears 1+BLANK_CYC cycles after rst drops.
- Params REFRESH_DIV = 8, BLANK_CYC = 2, auto_en = 0, sel = 1, src1 = 16'h12AF -> per slot 2 cycles an = F then 6 cycles active. Pattern is E/0x38, D/0x08, B/0x12, 7/0x4F. dp = 0 only on digit 1, from frame 2 onward.
- Auto rotation, ROTATE_FRAMES = 2, src0..3 = 0000/1111/2222/3333 -> cur_src steps 0,1,2,3,0 every 64 cycles. Shadow switches exactly at each boundary.
- hold = 1 with src0 changing 16'h0001 to 16'h0002 mid-frame -> display stays "0001" across 3 frames. Release hold -> "0002" from the next boundary.
- rst pulsed mid-slot with dig = 2 -> next cycle all outputs are at reset values, and the scan restarts at digit 0.
- With SSD_LZ_BLANK_EN and shadow = 16'h0040 -> digits 3 and 2 show 7F, digit 1 shows 0x4C, digit 0 shows 0x01. Without the macro, digits 3 and 2 show 0x01.
